// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampling 8N1 UART receiver with majority-vote bit sampling
module uart_rx_oversampled #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RsRx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);
  localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(8 + 1);
  localparam int HALF   = OVERSAMPLE / 2;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t r_state, w_next_state;

  logic              r_sync1, r_sync2, r_rx_prev;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [7:0]        r_shift;
  logic [1:0]        r_samp;
  logic [7:0]        r_data_out;
  logic              r_data_valid, r_framing_error;

  logic w_rx_s, w_tick, w_tick_last, w_start_edge, w_vote;
  logic w_at_lo, w_at_mid, w_at_hi;
  logic w_restart_div, w_load, w_ferr;

  assign w_rx_s       = r_sync2;
  assign w_start_edge = r_rx_prev & ~w_rx_s;
  assign w_tick       = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_tick_last  = (r_tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign w_at_lo      = w_tick && (r_tick_cnt == TICK_W'(HALF - 1));
  assign w_at_mid     = w_tick && (r_tick_cnt == TICK_W'(HALF));
  assign w_at_hi      = w_tick && (r_tick_cnt == TICK_W'(HALF + 1));
  assign w_vote       = (r_samp[1] & r_samp[0]) | (r_samp[1] & w_rx_s) | (r_samp[0] & w_rx_s);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_restart_div = 1'b0;
    w_load        = 1'b0;
    w_ferr        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_next_state  = START;
          w_restart_div = 1'b1;
        end
      end
      START: begin
        if (w_at_mid) w_next_state = w_rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (w_tick && w_tick_last && r_bit_cnt == BCNT_W'(8)) w_next_state = STOP;
      end
      STOP: begin
        // Leaving mid-stop-bit lets a back-to-back start edge be caught immediately.
        if (w_at_hi) begin
          if (w_vote) begin
            w_load       = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_ferr       = 1'b1;
            w_next_state = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (!w_rx_s)     w_restart_div = 1'b1;
        else if (w_tick) w_next_state  = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1         <= 1'b1;
      r_sync2         <= 1'b1;
      r_rx_prev       <= 1'b1;
      r_div_cnt       <= '0;
      r_tick_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_samp          <= '0;
      r_data_out      <= 8'h00;
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_sync1   <= RsRx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;

      if (w_restart_div || w_tick) r_div_cnt <= '0;
      else                         r_div_cnt <= r_div_cnt + DIV_W'(1);

      if (r_state == IDLE || r_state == WAIT_IDLE) r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= w_tick_last ? '0 : r_tick_cnt + TICK_W'(1);

      // r_bit_cnt counts bit boundaries seen in DATA; 0 means still in the start-bit tail.
      if (r_state != DATA)              r_bit_cnt <= '0;
      else if (w_tick && w_tick_last)   r_bit_cnt <= r_bit_cnt + BCNT_W'(1);

      if (w_at_lo || w_at_mid) r_samp <= {r_samp[0], w_rx_s};

      if (r_state == DATA && w_at_hi && r_bit_cnt != '0) r_shift <= {w_vote, r_shift[7:1]};

      if (w_load) r_data_out <= r_shift;
      r_data_valid    <= w_load;
      r_framing_error <= w_ferr;
    end
  end

  assign data_out      = r_data_out;
  assign data_valid    = r_data_valid;
  assign framing_error = r_framing_error;
  assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed self-checking bench for uart_rx_oversampled
module tb_uart_rx_oversampled;
  localparam int CLK_HZ = 614_400;
  localparam int BAUD   = 9600;
  localparam int OS     = 16;
  localparam int BIT    = (CLK_HZ / (BAUD * OS)) * OS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RsRx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, framing_error, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_wide = 0, n_overlap = 0, n_busy = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  logic prev_valid = 1'b0, prev_ferr = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_oversampled #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .RsRx(RsRx), .data_out(data_out),
    .data_valid(data_valid), .framing_error(framing_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_valid <= data_valid;
    prev_ferr  <= framing_error;
    if (busy) n_busy <= n_busy + 1;
    if (data_valid && framing_error) n_overlap <= n_overlap + 1;
    if (data_valid) begin
      if (prev_valid) n_wide <= n_wide + 1;
      else begin
        n_valid <= n_valid + 1;
        last_valid_cyc <= cyc;
        got_q.push_back(data_out);
      end
    end
    if (framing_error) begin
      if (prev_ferr) n_wide <= n_wide + 1;
      else n_ferr <= n_ferr + 1;
    end
  end

  task automatic hold(input logic v, input int n);
    @(posedge clk); #1;
    RsRx = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int glitch_bit);
    @(posedge clk); #1;
    RsRx = 1'b0;
    start_cyc = cyc;
    repeat (BIT - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        hold(b[i], 36);
        hold(1'b0, 4);
        hold(b[i], BIT - 40);
      end else begin
        hold(b[i], BIT);
      end
    end
    hold(stop, BIT);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", framing_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    hold(1'b1, BIT);
  endtask

  task automatic test_single;
    int v0, f0, lat;
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h41, 1'b1, -1);
    hold(1'b1, BIT);
    lat = last_valid_cyc - start_cyc;
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", n_valid - v0); end
    checks++; if (data_out !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", data_out); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", n_ferr - f0); end
    checks++; if (lat < 9 * BIT || lat > 10 * BIT) begin errors++; $display("FAIL single_latency: got %0d expected %0d..%0d", lat, 9 * BIT, 10 * BIT); end
  endtask

  task automatic test_framing;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h3C, 1'b0, -1);
    hold(1'b0, 30 * BIT);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b expected 1", busy); end
    hold(1'b1, 2 * BIT);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_recover_busy: got %b expected 0", busy); end
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 0", n_valid - v0); end
    checks++; if (data_out !== 8'h41) begin errors++; $display("FAIL ferr_hold_data: got %h expected 41", data_out); end
    send_byte(8'h7E, 1'b1, -1);
    hold(1'b1, BIT);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL recover_count: got %0d expected 1", n_valid - v0); end
    checks++; if (data_out !== 8'h7E) begin errors++; $display("FAIL recover_data: got %h expected 7e", data_out); end
  endtask

  task automatic test_back_to_back;
    got_q.delete();
    send_byte(8'h55, 1'b1, -1);
    send_byte(8'hAA, 1'b1, -1);
    hold(1'b1, BIT);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== 8'h55) begin errors++; $display("FAIL b2b_first: got %h expected 55", got_q[0]); end
      checks++; if (got_q[1] !== 8'hAA) begin errors++; $display("FAIL b2b_second: got %h expected aa", got_q[1]); end
    end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = n_valid;
    send_byte(8'hF0, 1'b1, 6);
    hold(1'b1, BIT);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", n_valid - v0); end
    checks++; if (data_out !== 8'hF0) begin errors++; $display("FAIL glitch_data: got %h expected f0", data_out); end
  endtask

  task automatic test_start_glitch;
    int v0, f0, b0;
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    hold(1'b0, 12);
    hold(1'b1, 2 * BIT);
    checks++; if (n_busy - b0 < 1) begin errors++; $display("FAIL sglitch_busy_seen: got %0d expected >0", n_busy - b0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sglitch_idle: got %b expected 0", busy); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL sglitch_valid: got %0d expected 0", n_valid - v0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL sglitch_ferr: got %0d expected 0", n_ferr - f0); end
  endtask

  task automatic test_reset_midframe;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, BIT);
    hold(1'b0, BIT);
    hold(1'b1, 32);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h expected 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", data_valid); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL mid_reset_ferr: got %b expected 0", framing_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    hold(1'b1, 20 * BIT);
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL mid_no_valid: got %0d expected 0", n_valid - v0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL mid_no_ferr: got %0d expected 0", n_ferr - f0); end
    send_byte(8'h12, 1'b1, -1);
    hold(1'b1, BIT);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL mid_next_count: got %0d expected 1", n_valid - v0); end
    checks++; if (data_out !== 8'h12) begin errors++; $display("FAIL mid_next_data: got %h expected 12", data_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_framing();
    test_back_to_back();
    test_glitch();
    test_start_glitch();
    test_reset_midframe();
    checks++; if (n_wide !== 0) begin errors++; $display("FAIL strobe_width: got %0d long pulses expected 0", n_wide); end
    checks++; if (n_overlap !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles expected 0", n_overlap); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD, default 9600, meaning the serial bit rate.
REQ-003 The module SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit; even, >= 8.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port RsRx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The module SHALL have port data_out, output, 8 bits: last correctly framed byte.
REQ-008 The module SHALL have port data_valid, output, 1 bit: one-cycle strobe when data_out updates.
REQ-009 The module SHALL have port framing_error, output, 1 bit: one-cycle strobe on bad stop bit.
REQ-010 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 RsRx SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rx_s.
REQ-012 A tick generator SHALL emit a one-cycle tick every DIV = CLK_HZ/(BAUD*OVERSAMPLE) clocks, truncated (651 at defaults; bit period 10416 clocks).
REQ-013 The tick counter SHALL restart from 0 when IDLE detects the start edge, so sampling is phase-aligned to that edge.
REQ-014 The state machine SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE -> START SHALL occur on a 1-to-0 transition of rx_s; the tick-count within the bit SHALL reset to 0.
REQ-016 START: at tick OVERSAMPLE/2, rx_s=1 -> IDLE (glitch rejected, no strobe); rx_s=0 -> DATA with bit index 0.
REQ-017 DATA: each bit SHALL be sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 of the bit, majority of three taken as the bit value.
REQ-018 Bits SHALL be assembled LSB first into a shift register; after bit index 7 completes (OVERSAMPLE ticks) -> STOP.
REQ-019 STOP: the stop bit SHALL be majority-sampled as in REQ-017, decided at tick OVERSAMPLE/2+1.
REQ-020 Stop bit 1: on the clock after the decision, data_out SHALL load the byte, data_valid SHALL pulse high for exactly 1 clock, state -> IDLE.
REQ-021 Stop bit 0: on the clock after the decision, framing_error SHALL pulse high for exactly 1 clock, data_out SHALL hold its previous value, state -> WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL remain until rx_s=1 for one full tick period, then -> IDLE; a break condition (line held low) SHALL produce exactly one framing_error.
REQ-023 Returning to IDLE mid-stop-bit SHALL allow a back-to-back start edge to be caught with no dead time beyond the half stop bit.
REQ-024 data_valid and framing_error SHALL never be high in the same cycle.
REQ-025 All counters SHALL be sized by $clog2 of their maximum and SHALL never wrap within a frame.

Reset
REQ-026 While reset=1 at a clock edge: state=IDLE, data_out=8'h00, data_valid=0, framing_error=0, busy=0, tick/bit counters=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no strobe; the next byte after reset release SHALL be received correctly.
REQ-028 Reset SHALL take priority over every state transition in the same cycle.

Verification
REQ-029 Send 0x41 at 9600 8N1 -> data_out=0x41, data_valid high exactly 1 clock, about 9.5 bit periods after start edge; framing_error stays 0.
REQ-030 Send 0x55 then 0xAA back-to-back with 1 stop bit -> two data_valid pulses with 0x55 then 0xAA, none missed.
REQ-031 Drive RsRx low for 3 ticks (1953 clocks) then high -> busy pulses, returns to IDLE, no data_valid/framing_error.
REQ-032 Send 0x3C with stop bit forced 0, then hold line low for 3 byte times -> exactly one framing_error pulse, data_out keeps the previous 0x41, recovery on next valid 0x7E.
REQ-033 Send 0xF0 with a single-tick low glitch at the centre sample of bit 6 -> majority vote yields data_out=0xF0.
REQ-034 Assert reset for 1 clock during bit 3 of 0x99 -> all outputs 0 next cycle, no strobe for that frame; following 0x12 is received correctly.
